// File: rtl/program_loader_pkg.sv
// program_loader_pkg
//   Shared definitions for the program loader, the processor it feeds, and
//   the bench. It holds the loader FSM state encoding, the fill value for
//   unloaded fetches, and the instruction opcode constants.
package program_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,   // waiting for LEN
        S_LOAD  = 3'd1,   // receiving LEN instruction bytes
        S_CHECK = 3'd2,   // waiting for the checksum byte
        S_RUN   = 3'd3,   // program resident, processor released
        S_ERROR = 3'd4    // frame rejected, wait for reload
    } state_t;

    // Returned for any fetch outside the resident program. It decodes as
    // "terminate unsuccessful", so a runaway processor stops cleanly.
    localparam logic [7:0] FILL_CODE = 8'b1000_0000;

    // Opcode classes live in the top two bits of an instruction.
    localparam logic [1:0] OPC_LOAD  = 2'b00;  // load-ops
    localparam logic [1:0] OPC_ARITH = 2'b01;  // arithmetic
    localparam logic [1:0] OPC_JZ    = 2'b10;  // jump if zero (low bits non-zero)
    localparam logic [1:0] OPC_JNZ   = 2'b11;  // jump if not zero (low bits non-zero)

    // A jump class with all-zero target bits means terminate.
    localparam logic [7:0] OP_TERM_OK   = 8'hC0;
    localparam logic [7:0] OP_TERM_FAIL = 8'h80;

endpackage

// File: rtl/program_loader_instr_ram.sv
// instr_ram
//   Instruction store: 2**ADDR_W x DATA_W, synchronous write, asynchronous
//   read so the processor sees the instruction in the same cycle it presents
//   the address. Contents are deliberately not reset.
// Ports:
//   clk    - write clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data (combinational from raddr)
module instr_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/program_loader.sv
// program_loader
//   Receives a framed program (LEN, LEN instruction bytes, CHK) over a
//   valid/ready byte stream, verifies that the 8-bit sum of the whole frame
//   is zero, stores it in instr_ram, and serves fetches to the processor.
//   The processor is held in reset until a verified program is resident.
// Ports:
//   clk, rst              - clock, asynchronous active-low reset
//   in_valid/in_data      - stream byte in
//   in_ready              - byte accepted this cycle when in_valid is high
//   restart               - pulse: one-cycle processor reset in S_RUN
//   reload                - pulse: drop program, wait for a new frame
//   instr_addr            - processor fetch address
//   instruction           - fetched instruction (combinational)
//   proc_rst              - active-high processor reset (registered)
//   loaded, error         - program resident / last frame rejected
//   prog_len              - number of valid instructions
module program_loader
    import program_loader_pkg::*;
#(
    parameter int              ADDR_W    = 8,
    parameter int              DATA_W    = 8,
    parameter logic [DATA_W-1:0] FILL_CODE = program_loader_pkg::FILL_CODE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              restart,
    input  logic              reload,
    input  logic [ADDR_W-1:0] instr_addr,
    output logic [DATA_W-1:0] instruction,
    output logic              proc_rst,
    output logic              loaded,
    output logic              error,
    output logic [ADDR_W-1:0] prog_len
);

    state_t            state;
    logic [ADDR_W-1:0] len_r;
    logic [ADDR_W-1:0] wptr;
    logic [7:0]        sum;
    logic [7:0]        sum_nxt;
    logic              xfer;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    // Only the three receive states accept bytes; S_RUN and S_ERROR
    // back-pressure the stream.
    assign in_ready = (state == S_IDLE) || (state == S_LOAD) || (state == S_CHECK);
    assign xfer     = in_valid && in_ready;
    assign sum_nxt  = sum + in_data;

    // reload wins over a coincident byte, so the write is suppressed too.
    assign ram_we = xfer && !reload && (state == S_LOAD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            len_r    <= '0;
            wptr     <= '0;
            sum      <= '0;
            proc_rst <= 1'b1;
            loaded   <= 1'b0;
            error    <= 1'b0;
            prog_len <= '0;
        end else if (reload) begin
            state    <= S_IDLE;
            proc_rst <= 1'b1;
            loaded   <= 1'b0;
            error    <= 1'b0;
            prog_len <= '0;
        end else begin
            case (state)
                S_IDLE: if (xfer) begin
                    sum  <= in_data;
                    wptr <= '0;
                    if (in_data == 8'd0) begin
                        state    <= S_ERROR;
                        error    <= 1'b1;
                        loaded   <= 1'b0;
                        prog_len <= '0;
                        proc_rst <= 1'b1;
                    end else begin
                        len_r <= ADDR_W'(in_data);
                        state <= S_LOAD;
                    end
                end
                S_LOAD: if (xfer) begin
                    sum  <= sum_nxt;
                    wptr <= wptr + ADDR_W'(1);
                    if (wptr == len_r - ADDR_W'(1)) state <= S_CHECK;
                end
                S_CHECK: if (xfer) begin
                    if (sum_nxt == 8'd0) begin
                        prog_len <= len_r;
                        loaded   <= 1'b1;
                        proc_rst <= 1'b0;
                        state    <= S_RUN;
                    end else begin
                        state    <= S_ERROR;
                        error    <= 1'b1;
                        loaded   <= 1'b0;
                        prog_len <= '0;
                        proc_rst <= 1'b1;
                    end
                end
                // restart is a one-cycle pulse, so following it gives a
                // one-cycle processor reset.
                S_RUN:   proc_rst <= restart;
                S_ERROR: proc_rst <= 1'b1;
                default: state    <= S_IDLE;
            endcase
        end
    end

    instr_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wptr),
        .wdata (DATA_W'(in_data)),
        .raddr (instr_addr),
        .rdata (ram_rdata)
    );

    assign instruction = (loaded && (instr_addr < prog_len)) ? ram_rdata : FILL_CODE;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;
    import program_loader_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       restart = 1'b0;
    logic       reload = 1'b0;
    logic [7:0] instr_addr = 8'h00;
    logic [7:0] instruction;
    logic       proc_rst;
    logic       loaded;
    logic       error;
    logic [7:0] prog_len;

    int checks = 0;
    int errors = 0;

    program_loader #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .restart     (restart),
        .reload      (reload),
        .instr_addr  (instr_addr),
        .instruction (instruction),
        .proc_rst    (proc_rst),
        .loaded      (loaded),
        .error       (error),
        .prog_len    (prog_len)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] bytes [10];
        int         n;
        logic       exp_loaded;
        logic       exp_error;
        logic [7:0] exp_len;
        logic [7:0] a1, e1, a2, e2;
    } vec_t;

    vec_t vt [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offer one byte from a negedge; it transfers on the following posedge.
    task automatic send_byte(input logic [7:0] b);
        int wait_cyc;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        wait_cyc = 0;
        while (!in_ready && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (!in_ready) begin
            chk("send_byte ready timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic end_stream();
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic send_frame(input vec_t v, input bit gaps);
        for (int i = 0; i < v.n; i++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 3);
                for (int k = 0; k < g; k++) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    in_data  = 8'($urandom);
                end
            end
            send_byte(v.bytes[i]);
        end
        end_stream();
    endtask

    task automatic pulse_reload();
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        chk("reload in_ready", 32'(in_ready), 32'd1);
        chk("reload error",    32'(error),    32'd0);
        chk("reload loaded",   32'(loaded),   32'd0);
        chk("reload prog_len", 32'(prog_len), 32'd0);
        chk("reload proc_rst", 32'(proc_rst), 32'd1);
    endtask

    task automatic fetch(input string name, input logic [7:0] a, input logic [7:0] e);
        instr_addr = a;
        #1;
        chk(name, 32'(instruction), 32'(e));
    endtask

    initial begin
        vec_t v;
        // Self-test program, good checksum.
        vt[0].bytes = '{8'h06, 8'h13, 8'h44, 8'h4D, 8'h56, 8'h5F, 8'hC0, 8'hE1, 8'h00, 8'h00};
        vt[0].n = 8; vt[0].exp_loaded = 1; vt[0].exp_error = 0; vt[0].exp_len = 8'd6;
        vt[0].a1 = 8'd2; vt[0].e1 = 8'h4D; vt[0].a2 = 8'd6; vt[0].e2 = OP_TERM_FAIL;
        // Same frame, checksum off by one.
        vt[1].bytes = '{8'h06, 8'h13, 8'h44, 8'h4D, 8'h56, 8'h5F, 8'hC0, 8'hE2, 8'h00, 8'h00};
        vt[1].n = 8; vt[1].exp_loaded = 0; vt[1].exp_error = 1; vt[1].exp_len = 8'd0;
        vt[1].a1 = 8'd0; vt[1].e1 = 8'h80; vt[1].a2 = 8'd2; vt[1].e2 = 8'h80;
        // Single instruction: 01 + C0 + 3F = 0x100.
        vt[2].bytes = '{8'h01, 8'hC0, 8'h3F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vt[2].n = 3; vt[2].exp_loaded = 1; vt[2].exp_error = 0; vt[2].exp_len = 8'd1;
        vt[2].a1 = 8'd0; vt[2].e1 = 8'hC0; vt[2].a2 = 8'd1; vt[2].e2 = 8'h80;
        // Zero length goes straight to error.
        vt[3].bytes = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vt[3].n = 1; vt[3].exp_loaded = 0; vt[3].exp_error = 1; vt[3].exp_len = 8'd0;
        vt[3].a1 = 8'd0; vt[3].e1 = 8'h80; vt[3].a2 = 8'd255; vt[3].e2 = 8'h80;
        // 03 + AA + BB + CC = 0x234 -> checksum CC.
        vt[4].bytes = '{8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hCC, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vt[4].n = 5; vt[4].exp_loaded = 1; vt[4].exp_error = 0; vt[4].exp_len = 8'd3;
        vt[4].a1 = 8'd2; vt[4].e1 = 8'hCC; vt[4].a2 = 8'd3; vt[4].e2 = 8'h80;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst proc_rst", 32'(proc_rst), 32'd1);
        chk("rst loaded",   32'(loaded),   32'd0);
        chk("rst error",    32'(error),    32'd0);
        chk("rst prog_len", 32'(prog_len), 32'd0);
        fetch("rst fetch", 8'd0, 8'h80);
        rst = 1'b1;

        // Table-driven frames.
        for (int t = 0; t < 5; t++) begin
            pulse_reload();
            send_frame(vt[t], 1'b0);
            chk($sformatf("v%0d loaded", t),   32'(loaded),   32'(vt[t].exp_loaded));
            chk($sformatf("v%0d error", t),    32'(error),    32'(vt[t].exp_error));
            chk($sformatf("v%0d prog_len", t), 32'(prog_len), 32'(vt[t].exp_len));
            chk($sformatf("v%0d proc_rst", t), 32'(proc_rst), 32'(!vt[t].exp_loaded));
            chk($sformatf("v%0d in_ready", t), 32'(in_ready), 32'd0);
            fetch($sformatf("v%0d fetch a1", t), vt[t].a1, vt[t].e1);
            fetch($sformatf("v%0d fetch a2", t), vt[t].a2, vt[t].e2);
        end

        // restart in S_RUN: exactly one cycle of proc_rst.
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("restart pulse hi", 32'(proc_rst), 32'd1);
        @(negedge clk);
        chk("restart pulse lo", 32'(proc_rst), 32'd0);
        chk("restart loaded",   32'(loaded),   32'd1);

        // Bytes offered in S_RUN are not consumed.
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (3) begin
            @(negedge clk);
            chk("run backpressure in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        chk("run backpressure prog_len", 32'(prog_len), 32'd3);
        fetch("run backpressure fetch", 8'd0, 8'hAA);

        // reload coinciding with a transfer in S_LOAD drops the byte.
        pulse_reload();
        send_byte(8'h06);
        send_byte(8'h13);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h44;
        reload   = 1'b1;
        @(negedge clk);
        reload   = 1'b0;
        in_valid = 1'b0;
        chk("reload+xfer in_ready", 32'(in_ready), 32'd1);
        chk("reload+xfer prog_len", 32'(prog_len), 32'd0);
        chk("reload+xfer loaded",   32'(loaded),   32'd0);
        send_frame(vt[2], 1'b0);
        chk("after reload+xfer loaded",   32'(loaded),   32'd1);
        chk("after reload+xfer prog_len", 32'(prog_len), 32'd1);

        // Random gaps on in_valid must give the same RAM image.
        pulse_reload();
        send_frame(vt[0], 1'b1);
        chk("gaps loaded",   32'(loaded),   32'd1);
        chk("gaps prog_len", 32'(prog_len), 32'd6);
        for (int i = 0; i < 6; i++)
            fetch($sformatf("gaps fetch %0d", i), 8'(i), vt[0].bytes[i+1]);

        // Asynchronous reset in S_RUN and then mid-S_LOAD.
        #2 rst = 1'b0;
        #1;
        chk("arst run proc_rst", 32'(proc_rst), 32'd1);
        chk("arst run loaded",   32'(loaded),   32'd0);
        chk("arst run in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        send_byte(8'h03);
        send_byte(8'hAA);
        #2 rst = 1'b0;
        #1;
        chk("arst load in_ready", 32'(in_ready), 32'd1);
        chk("arst load proc_rst", 32'(proc_rst), 32'd1);
        chk("arst load loaded",   32'(loaded),   32'd0);
        chk("arst load error",    32'(error),    32'd0);
        chk("arst load prog_len", 32'(prog_len), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        v = vt[0];
        send_frame(v, 1'b0);
        chk("resend loaded",   32'(loaded),   32'd1);
        chk("resend prog_len", 32'(prog_len), 32'd6);
        chk("resend proc_rst", 32'(proc_rst), 32'd0);
        fetch("resend fetch 5", 8'd5, OP_TERM_OK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer and server side of the processor instruction-fetch interface.
- Receives a framed program over a valid/ready byte stream, verifies a checksum, and stores the program in a 256x8 instruction RAM.
- Drives `instruction` combinationally from the processor's `instr_addr`.
- Holds the processor in reset until a verified program is resident, and can restart or reload it.

Parameters:
- ADDR_W, 8, instruction address width; RAM depth is 2**ADDR_W.
- DATA_W, 8, instruction width.
- FILL_CODE, 8'b10000000, value returned for unloaded or out-of-range addresses (decodes as "terminate unsuccessful").

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  stream byte valid.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- restart  input  1  single-cycle pulse; re-run the resident program.
- reload  input  1  single-cycle pulse; discard the program and await a new frame.
- instr_addr  input  ADDR_W  processor fetch address.
- instruction  output  DATA_W  fetched instruction, combinational from instr_addr.
- proc_rst  output  1  active-high reset to the processor.
- loaded  output  1  verified program resident.
- error  output  1  last frame rejected.
- prog_len  output  ADDR_W  number of valid instructions.

Behaviour:
- Reset (rst=0, asynchronous): state=S_IDLE, in_ready=1, proc_rst=1, loaded=0, error=0, prog_len=0, running checksum=0, write pointer=0. RAM contents are not cleared.
- Transfer: a byte moves on a clk edge when in_valid && in_ready. in_data is ignored otherwise.
- Frame format: LEN, then LEN instruction bytes, then CHK. The frame is valid when the 8-bit sum (LEN + all instructions + CHK) mod 256 == 0.
- S_IDLE (in_ready=1), on transfer:
  - sum <= in_data, wptr <= 0.
  - LEN == 0: go to S_ERROR.
  - Otherwise: latch LEN into len_r and go to S_LOAD.
- S_LOAD (in_ready=1), on transfer:
  - mem[wptr] <= in_data, sum <= sum + in_data, wptr <= wptr + 1.
  - When wptr == len_r - 1: go to S_CHECK.
  - wptr never wraps, since LEN <= 255.
- S_CHECK (in_ready=1), on transfer:
  - (sum + in_data) mod 256 == 0: prog_len <= len_r, loaded <= 1, go to S_RUN.
  - Otherwise: go to S_ERROR.
- S_RUN (in_ready=0):
  - proc_rst=0 from the first cycle in S_RUN.
  - restart=1: proc_rst=1 for exactly that one following cycle, stay in S_RUN.
  - Further stream bytes are back-pressured.
- S_ERROR (in_ready=0): error=1, loaded=0, prog_len=0, proc_rst=1. Leave only on reload.
- reload (any state): next state S_IDLE, loaded=0, error=0, prog_len=0, proc_rst=1. reload has priority over restart and over a simultaneous transfer; that byte is dropped.
- proc_rst is registered and equals 1 in every state except S_RUN, apart from the restart pulse.
- instruction:
  - mem[instr_addr] when loaded && instr_addr < prog_len.
  - FILL_CODE otherwise.
  - Zero latency (asynchronous-read RAM), because the processor samples instruction in the same cycle it presents instr_addr.
- A write and a fetch never coincide, since the processor is held in reset during S_LOAD.
- Reset mid-frame: the partial program is abandoned and the frame must be resent from LEN.

Decomposition:
- Shared package/defines:
  - state encodings (S_IDLE, S_LOAD, S_CHECK, S_RUN, S_ERROR);
  - FILL_CODE;
  - instruction opcode constants (load-ops, arith, jz, jnz, terminate 0xC0/0x80), reused by the processor and the bench.
- One sub-module: instr_ram, 256x8, synchronous write, asynchronous read.
- The frame FSM, checksum and proc_rst sequencing stay in program_loader.

Test Plan:
- Self-test load: send 06,13,44,4D,56,5F,C0,E1 -> loaded=1, prog_len=6, proc_rst falls the cycle after E1; instr_addr=2 gives 4D; instr_addr=6 gives 80.
- Bad checksum: same frame ending E2 -> error=1, loaded=0, proc_rst=1, in_ready=0; instr_addr=0 gives 80.
- Zero length: send 00 -> S_ERROR immediately; reload -> in_ready=1, error=0.
- Back-pressure and gaps: in_valid toggled randomly during load -> identical RAM image; bytes offered in S_RUN are not consumed (in_ready=0).
- restart in S_RUN -> proc_rst high exactly one cycle; reload together with a transfer in S_LOAD -> byte dropped, state S_IDLE, prog_len=0.
- Asynchronous reset asserted mid-S_LOAD -> all outputs return to reset values immediately; a full resend loads correctly.
